// File: rtl/dmem_responder_pkg.sv
// Types and constants shared by the dmem responder and the LSU side.
package dmem_responder_pkg;

   localparam int BYTE_W          = 8;
   localparam int MEM_LATENCY_MAX = 15;

   typedef enum logic [1:0] {
      MEM_B = 2'd0,
      MEM_H = 2'd1,
      MEM_W = 2'd2,
      MEM_D = 2'd3
   } mem_size_t;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_WAIT = 2'd1,
      ST_RESP = 2'd2
   } dmem_state_t;

endpackage

// File: rtl/dmem_responder_byte_array.sv
// Byte-addressable backing store split into FETCH_WIDTH/8 lanes; rotates between
// request byte order and lane order so unaligned accesses take a single cycle.
module dmem_byte_array
   import dmem_responder_pkg::*;
#(
   parameter int FETCH_WIDTH = 64,
   parameter int DEPTH_BYTES = 4096
)
(
   input  logic                              clk,
   input  logic [$clog2(DEPTH_BYTES)-1:0]    addr,
   output logic [FETCH_WIDTH-1:0]            rd_data,
   input  logic                              wr_en,
   input  logic [FETCH_WIDTH/BYTE_W-1:0]     wr_be,
   input  logic [FETCH_WIDTH-1:0]            wr_data
);

   localparam int NL   = FETCH_WIDTH / BYTE_W;
   localparam int LW   = $clog2(NL);
   localparam int AW   = $clog2(DEPTH_BYTES);
   localparam int RW   = AW - LW;
   localparam int ROWS = DEPTH_BYTES / NL;

   logic [LW-1:0]                  base_lane;
   logic [RW-1:0]                  base_row;
   logic [NL-1:0][RW-1:0]          lane_row;
   logic [NL-1:0][BYTE_W-1:0]      lane_rd;
   logic [NL-1:0][BYTE_W-1:0]      lane_wd;
   logic [NL-1:0]                  lane_we;

   assign base_lane = addr[LW-1:0];
   assign base_row  = addr[AW-1:LW];

   // Lanes below the starting lane hold bytes that spill into the next row.
   always_comb begin
      lane_row = '0;
      for (int j = 0; j < NL; j++) begin
         lane_row[j] = (LW'(j) >= base_lane) ? base_row : base_row + RW'(1);
      end
   end

   always_comb begin
      rd_data = '0;
      lane_wd = '0;
      lane_we = '0;
      for (int k = 0; k < NL; k++) begin
         rd_data[k*BYTE_W +: BYTE_W]     = lane_rd[base_lane + LW'(k)];
         lane_wd[base_lane + LW'(k)]     = wr_data[k*BYTE_W +: BYTE_W];
         lane_we[base_lane + LW'(k)]     = wr_en & wr_be[k];
      end
   end

   for (genvar j = 0; j < NL; j++) begin : g_lane
      logic [BYTE_W-1:0] mem [ROWS];

      always_ff @(posedge clk) begin
         if (lane_we[j]) begin
            mem[lane_row[j]] <= lane_wd[j];
         end
      end

      assign lane_rd[j] = mem[lane_row[j]];
   end

endmodule

// File: rtl/dmem_responder.sv
// Data-memory target for the LSU: one request at a time, fixed programmable latency,
// single-cycle rdy pulse with per-byte range checking.
//
//  state   | meaning
//  --------+-----------------------------------------------------------
//  IDLE    | waiting for rd_en_i/wr_en_i; request captured on accept
//  WAIT    | latency countdown, busy_o high
//  RESP    | rdy_o (and err_o) pulse; store commits on the exit edge
module dmem_responder
   import dmem_responder_pkg::*;
#(
   parameter int DATA_WIDTH  = 64,
   parameter int FETCH_WIDTH = 64,
   parameter int DEPTH_BYTES = 4096,
   parameter int LATENCY     = 2
)
(
   input  logic                                   clk,
   input  logic                                   rst,
   input  logic                                   rd_en_i,
   input  logic                                   wr_en_i,
   input  logic [DATA_WIDTH-1:0]                  addr_i,
   input  logic [$clog2(FETCH_WIDTH/BYTE_W)-1:0]  wr_size_i,
   input  logic [FETCH_WIDTH-1:0]                 wr_data_i,
   output logic                                   busy_o,
   output logic                                   rdy_o,
   output logic [FETCH_WIDTH-1:0]                 rd_data_o,
   output logic                                   err_o
);

   localparam int NL = FETCH_WIDTH / BYTE_W;
   localparam int SW = $clog2(NL);
   localparam int AW = $clog2(DEPTH_BYTES);
   localparam int CW = $clog2(MEM_LATENCY_MAX + 1);
   localparam logic [CW-1:0] CNT_LOAD = CW'(LATENCY - 1);

   dmem_state_t             state, state_nxt;
   logic [CW-1:0]           cnt;
   logic [DATA_WIDTH-1:0]   addr_q, cur_addr;
   logic [SW-1:0]           size_q, cur_size;
   logic [FETCH_WIDTH-1:0]  wdata_q, arr_rd, rd_masked;
   logic                    store_q, cur_store;
   logic                    req, accept, arr_we, range_err;
   logic [NL-1:0]           byte_ok, byte_acc, wr_be;

   assign req    = rd_en_i | wr_en_i;
   assign accept = (state == ST_IDLE) && req;

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state <= ST_IDLE;
      end else begin
         state <= state_nxt;
      end
   end

   always_comb begin
      state_nxt = state;
      case (state)
         ST_IDLE: if (req) state_nxt = (LATENCY > 1) ? ST_WAIT : ST_RESP;
         ST_WAIT: if (cnt == CW'(1)) state_nxt = ST_RESP;
         ST_RESP: state_nxt = ST_IDLE;
         default: state_nxt = ST_IDLE;
      endcase
   end

   always_comb begin
      busy_o = 1'b0;
      rdy_o  = 1'b0;
      err_o  = 1'b0;
      if (state != ST_IDLE) busy_o = 1'b1;
      if (state == ST_RESP) begin
         rdy_o = 1'b1;
         err_o = range_err;
      end
   end

   // In IDLE the live request drives the array so LATENCY=1 can register read data on accept.
   assign cur_addr  = (state == ST_IDLE) ? addr_i    : addr_q;
   assign cur_size  = (state == ST_IDLE) ? wr_size_i : size_q;
   assign cur_store = (state == ST_IDLE) ? wr_en_i   : store_q;

   always_comb begin
      byte_ok  = '0;
      byte_acc = '0;
      for (int k = 0; k < NL; k++) begin
         byte_ok[k]  = ({1'b0, cur_addr} + (DATA_WIDTH+1)'(k)) < (DATA_WIDTH+1)'(DEPTH_BYTES);
         byte_acc[k] = !cur_store || (k < (1 << cur_size));
      end
   end

   assign range_err = |(byte_acc & ~byte_ok);
   assign wr_be     = byte_acc & byte_ok;
   assign arr_we    = (state == ST_RESP) && store_q;

   always_comb begin
      rd_masked = '0;
      for (int k = 0; k < NL; k++) begin
         rd_masked[k*BYTE_W +: BYTE_W] = byte_ok[k] ? arr_rd[k*BYTE_W +: BYTE_W] : '0;
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         cnt       <= '0;
         addr_q    <= '0;
         size_q    <= '0;
         wdata_q   <= '0;
         store_q   <= 1'b0;
         rd_data_o <= '0;
      end else begin
         if (accept) begin
            cnt     <= CNT_LOAD;
            addr_q  <= addr_i;
            size_q  <= wr_size_i;
            wdata_q <= wr_data_i;
            store_q <= wr_en_i;
         end else if (state == ST_WAIT) begin
            cnt <= cnt - CW'(1);
         end
         if (state_nxt == ST_RESP) begin
            rd_data_o <= cur_store ? '0 : rd_masked;
         end
      end
   end

   dmem_byte_array #(
      .FETCH_WIDTH (FETCH_WIDTH),
      .DEPTH_BYTES (DEPTH_BYTES)
   ) u_array (
      .clk     (clk),
      .addr    (cur_addr[AW-1:0]),
      .rd_data (arr_rd),
      .wr_en   (arr_we),
      .wr_be   (wr_be),
      .wr_data (wdata_q)
   );

   a_single_op: assert property (@(posedge clk) disable iff (!rst)
      (state == ST_IDLE) |-> !(rd_en_i && wr_en_i));

endmodule
